// File: rtl/router_fsm_nch.sv
// rtl/router_fsm_nch.sv - router control FSM for NUM_CH output channels with invalid-address drop path
//
// Decodes the packet header address, sequences header/payload/parity writes into the
// selected channel FIFO, stalls while that FIFO is full and waits for it to drain
// before starting a new packet. Headers addressing a channel >= NUM_CH are consumed
// and discarded in DROP_PKT.
//
// Optional feature macro: ROUTER_WAIT_TIMEOUT_EN
//   defined   : WAIT_TILL_EMPTY gives up after WAIT_CYCLES cycles, drops the packet and
//               pulses timeout_err
//   undefined : WAIT_TILL_EMPTY waits indefinitely, timeout_err tied 0
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   pkt_valid             packet in progress on data_in
//   data_in               header address field, sampled in DECODE_ADDRESS only
//   fifo_full/fifo_empty  per-channel FIFO status
//   soft_reset            per-channel soft reset pulse (read timeout)
//   parity_done           parity byte written
//   low_pkt_valid         pkt_valid fell while the FIFO was full
//   dest_sel              one-hot write select of the latched destination
//   write_enb_reg         FIFO write enable (LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL)
//   detect_add .. drop_state  state decodes
//   busy                  input stalled
//   timeout_err           one-cycle pulse on wait timeout
module router_fsm_nch #(
  parameter int NUM_CH      = 3,
  parameter int ADDR_W      = 2,
  parameter int WAIT_CYCLES = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic [NUM_CH-1:0] dest_sel,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              drop_state,
  output logic              busy,
  output logic              timeout_err
);

  if (NUM_CH < 2 || NUM_CH > 16 || (2 ** ADDR_W) < NUM_CH || WAIT_CYCLES < 1) begin : g_bad_param
    $error("router_fsm_nch: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    LOAD_PARITY        = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    WAIT_TILL_EMPTY    = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PKT           = 4'd8
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] dest_addr;

  // Address -> one-hot channel mask; addresses >= NUM_CH give an all-zero mask,
  // which keeps every per-channel mux safe for out-of-range addresses.
  function automatic logic [NUM_CH-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (a == ADDR_W'(i)) onehot[i] = 1'b1;
    end
  endfunction

  logic [NUM_CH-1:0] dest_oh;
  logic [NUM_CH-1:0] in_oh;
  logic              sel_full;
  logic              sel_empty;
  logic              sel_soft;
  logic              in_valid;
  logic              in_empty;

  assign dest_oh   = onehot(dest_addr);
  assign in_oh     = onehot(data_in);
  assign sel_full  = |(fifo_full  & dest_oh);
  assign sel_empty = |(fifo_empty & dest_oh);
  assign sel_soft  = |(soft_reset & dest_oh);
  assign in_valid  = |in_oh;
  assign in_empty  = |(fifo_empty & in_oh);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DECODE_ADDRESS;
      dest_addr <= '0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ROUTER_WAIT_TIMEOUT_EN
      timeout_err <= 1'b0;
      // Held at zero outside WAIT_TILL_EMPTY so every entry starts a fresh count.
      if (state != WAIT_TILL_EMPTY) wait_cnt <= '0;
`endif
      // A soft reset only matters for the channel currently being written.
      if (state != DECODE_ADDRESS && sel_soft) begin
        state     <= DECODE_ADDRESS;
        dest_addr <= '0;
      end else begin
        case (state)
          DECODE_ADDRESS: begin
            if (pkt_valid) begin
              dest_addr <= data_in;
              if (!in_valid)     state <= DROP_PKT;
              else if (in_empty) state <= LOAD_FIRST_DATA;
              else               state <= WAIT_TILL_EMPTY;
            end
          end
          LOAD_FIRST_DATA: state <= LOAD_DATA;
          LOAD_DATA: begin
            if (sel_full)        state <= FIFO_FULL_STATE;
            else if (!pkt_valid) state <= LOAD_PARITY;
          end
          LOAD_PARITY: state <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: begin
            if (sel_full) state <= FIFO_FULL_STATE;
            else          state <= DECODE_ADDRESS;
          end
          FIFO_FULL_STATE: begin
            if (!sel_full) state <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)        state <= DECODE_ADDRESS;
            else if (low_pkt_valid) state <= LOAD_PARITY;
            else                    state <= LOAD_DATA;
          end
          WAIT_TILL_EMPTY: begin
`ifdef ROUTER_WAIT_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
            // Target draining on the last allowed cycle still wins over the timeout.
            if (sel_empty) begin
              state <= LOAD_FIRST_DATA;
            end else if (wait_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
              state       <= DROP_PKT;
              timeout_err <= 1'b1;
            end
`else
            if (sel_empty) state <= LOAD_FIRST_DATA;
`endif
          end
          DROP_PKT: begin
            if (!pkt_valid) state <= DECODE_ADDRESS;
          end
          default: state <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  // Moore outputs: pure decodes of the registered state and destination.
  assign detect_add    = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign drop_state    = (state == DROP_PKT);
  assign write_enb_reg = ld_state | (state == LOAD_PARITY) | laf_state;
  assign busy          = lfd_state | (state == LOAD_PARITY) | full_state | laf_state
                       | (state == WAIT_TILL_EMPTY) | rst_int_reg;
  assign dest_sel      = (detect_add || drop_state) ? '0 : dest_oh;

endmodule

// File: tb/tb_router_fsm_nch.sv
// tb/tb_router_fsm_nch.sv - self-checking bench for router_fsm_nch with per-cycle reference model
module tb_router_fsm_nch;
  localparam int NUM_CH      = 3;
  localparam int ADDR_W      = 2;
  localparam int WAIT_CYCLES = 30;

  localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_LP = 3, P_FULL = 4;
  localparam int P_LAF = 5, P_WAIT = 6, P_CPE = 7, P_DROP = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [NUM_CH-1:0] dest_sel;
  logic write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic rst_int_reg, drop_state, busy, timeout_err;

  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .dest_sel(dest_sel),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .drop_state(drop_state), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet phase, latched address, waited-cycle count.
  int m_ph   = -1;
  int m_addr = 0;
  int m_wait = 0;
  bit m_terr = 1'b0;

  always @(posedge clock) begin
    bit full_s, empty_s;
    m_terr = 1'b0;
    if (reset) begin
      m_ph = P_DEC; m_addr = 0; m_wait = 0;
    end else if (m_ph >= 0) begin
      full_s  = (m_addr < NUM_CH) ? fifo_full[m_addr]  : 1'b0;
      empty_s = (m_addr < NUM_CH) ? fifo_empty[m_addr] : 1'b0;
      if (m_ph != P_DEC && m_addr < NUM_CH && soft_reset[m_addr]) begin
        m_ph = P_DEC; m_addr = 0;
      end else begin
        case (m_ph)
          P_DEC: if (pkt_valid) begin
            m_addr = int'(data_in);
            if (m_addr >= NUM_CH)        m_ph = P_DROP;
            else if (fifo_empty[m_addr]) m_ph = P_LFD;
            else begin m_ph = P_WAIT; m_wait = 0; end
          end
          P_LFD:  m_ph = P_LD;
          P_LD:   if (full_s) m_ph = P_FULL; else if (!pkt_valid) m_ph = P_LP;
          P_LP:   m_ph = P_CPE;
          P_CPE:  m_ph = full_s ? P_FULL : P_DEC;
          P_FULL: if (!full_s) m_ph = P_LAF;
          P_LAF:  m_ph = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
          P_WAIT: if (empty_s) m_ph = P_LFD;
                  else begin
                    m_wait++;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                    if (m_wait == WAIT_CYCLES) begin m_ph = P_DROP; m_terr = 1'b1; end
`endif
                  end
          P_DROP: if (!pkt_valid) m_ph = P_DEC;
          default: m_ph = P_DEC;
        endcase
      end
    end
  end

  function automatic logic [12:0] exp_vec(input int ph, input int addr, input bit terr);
    logic [NUM_CH-1:0] ds;
    bit wen, bsy;
    ds  = (ph != P_DEC && ph != P_DROP) ? (NUM_CH'(1) << addr) : '0;
    wen = (ph == P_LD) || (ph == P_LP) || (ph == P_LAF);
    bsy = (ph == P_LFD) || (ph == P_LP) || (ph == P_FULL) || (ph == P_LAF)
       || (ph == P_WAIT) || (ph == P_CPE);
    exp_vec = {ds, ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_LAF, ph == P_FULL,
               ph == P_CPE, ph == P_DROP, wen, bsy, terr};
  endfunction

  always @(posedge clock) begin
    #2;
    if (m_ph >= 0)
      chk("outputs", {3'b0, dest_sel, detect_add, lfd_state, ld_state, laf_state, full_state,
                      rst_int_reg, drop_state, write_enb_reg, busy, timeout_err},
          {3'b0, exp_vec(m_ph, m_addr, m_terr)});
  end

  int wen_n, full_n, busy_n;

  task automatic tick;
    @(negedge clock);
    wen_n  += int'(write_enb_reg);
    full_n += int'(full_state);
    busy_n += int'(busy);
  endtask

  task automatic clr;
    wen_n = 0; full_n = 0; busy_n = 0;
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; fifo_full = '0; fifo_empty = 3'b111;
    soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
    tick; tick;
    chk("rst_detect_add", 16'(detect_add), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_dest_sel", 16'(dest_sel), 16'd0);
    reset = 1'b0;
    tick;

    // Normal packet to channel 2, four payload cycles.
    clr; pkt_valid = 1'b1; data_in = 2'd2;
    tick; chk("s1_lfd", 16'(lfd_state), 16'd1);
    tick; chk("s1_dest_sel", 16'(dest_sel), 16'b100);
    tick; tick; tick;
    pkt_valid = 1'b0;
    tick; tick; chk("s1_cpe", 16'(rst_int_reg), 16'd1);
    tick; chk("s1_back_decode", 16'(detect_add), 16'd1);
    chk("s1_wen_cycles", 16'(wen_n), 16'd5);

    // Wait on channel 1 only; channel 0 empty toggles must not matter.
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    tick; chk("s2_wait_busy", 16'(busy), 16'd1);
    fifo_empty = 3'b100; tick;
    fifo_empty = 3'b101; tick; chk("s2_still_wait", 16'(lfd_state), 16'd0);
    fifo_empty = 3'b111; tick; chk("s2_lfd", 16'(lfd_state), 16'd1);
    tick; pkt_valid = 1'b0; tick; tick; tick;

    // FIFO full stall on channel 0, then low_pkt_valid path.
    clr; pkt_valid = 1'b1; data_in = 2'd0;
    tick; tick;
    fifo_full = 3'b001; tick; tick; tick;
    fifo_full = 3'b000; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    tick; chk("s3_laf", 16'(laf_state), 16'd1);
    tick; low_pkt_valid = 1'b0;
    tick; tick;
    chk("s3_full_cycles", 16'(full_n), 16'd3);

    // Invalid address 3 -> drop.
    clr; pkt_valid = 1'b1; data_in = 2'd3;
    tick; chk("s4_drop", 16'(drop_state), 16'd1);
    chk("s4_busy", 16'(busy), 16'd0);
    tick; tick;
    pkt_valid = 1'b0;
    tick; chk("s4_decode", 16'(detect_add), 16'd1);
    chk("s4_no_writes", 16'(wen_n), 16'd0);

    // Soft reset: wrong channel ignored, matching channel aborts.
    pkt_valid = 1'b1; data_in = 2'd1;
    tick; tick;
    soft_reset = 3'b001; tick; chk("s5_ignored", 16'(ld_state), 16'd1);
    soft_reset = 3'b010; tick; chk("s5_abort", 16'(detect_add), 16'd1);
    chk("s5_dest_sel", 16'(dest_sel), 16'd0);
    soft_reset = 3'b000; pkt_valid = 1'b0;
    tick;
    soft_reset = 3'b001; tick; chk("s5_dec_soft", 16'(detect_add), 16'd1);
    soft_reset = 3'b000; tick;

`ifdef ROUTER_WAIT_TIMEOUT_EN
    // Target never drains -> drop after WAIT_CYCLES cycles of waiting.
    clr; pkt_valid = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    repeat (WAIT_CYCLES) tick;
    chk("s6_wait_cycles", 16'(busy_n), 16'(WAIT_CYCLES));
    tick; chk("s6_drop", 16'(drop_state), 16'd1);
    chk("s6_terr", 16'(timeout_err), 16'd1);
    tick; chk("s6_terr_pulse", 16'(timeout_err), 16'd0);
    pkt_valid = 1'b0; fifo_empty = 3'b111;
    tick;
`endif

    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
